// File: rtl/sd_mode_ctrl.sv
// sd_mode_ctrl: measures video timing, qualifies a stable mode and drives scandoubler enable, HQ2x select and mute
module sd_mode_ctrl #(
  parameter int STABLE_FRAMES = 3,
  parameter int MUTE_FRAMES   = 2,
  parameter int MIN_LINE_CLKS = 2000,
  parameter int LINE_TOL      = 2,
  parameter int TIMEOUT_LOG2  = 22
) (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        hb_in,
  input  logic        vb_in,
  input  logic        sd_req,
  input  logic        hq2x_req,
  output logic        sd_en,
  output logic        hq2x_en,
  output logic        mute,
  output logic        mode_valid,
  output logic [15:0] line_clks,
  output logic [7:0]  pix_clks,
  output logic [9:0]  active_lines
);
  typedef enum logic [1:0] {UNLOCK, CHECK, APPLY, LOCK} state_t;
  state_t state_q;
  logic ce_q, hs_q, vs_q, hb_q, vb_q, ce_p_q, hs_p_q, vs_p_q, hb_p_q;
  logic sd_req_q, hq_req_q, app_sd_q, app_hq_q;
  logic [15:0] line_cnt_q, line_per_q, ref_line_q, line_d, line_diff;
  logic [7:0] pix_cnt_q, pix_per_q, ref_pix_q, pix_d;
  logic [9:0] act_cnt_q, ref_lines_q;
  logic [3:0] match_cnt_q, mute_cnt_q, match_d;
  logic [TIMEOUT_LOG2-1:0] to_q;
  logic ce_rise, hs_rise, fe, hb_fall, to_sat, m_valid, m_match, pend, allow;
  assign ce_rise   = ce_q & ~ce_p_q;
  assign hs_rise   = hs_q & ~hs_p_q;
  assign fe        = vs_q & ~vs_p_q;
  assign hb_fall   = ~hb_q & hb_p_q;
  assign line_d    = (&line_cnt_q) ? line_cnt_q : line_cnt_q + 16'd1;
  assign pix_d     = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + 8'd1;
  assign to_sat    = &to_q;
  assign m_valid   = ~&line_per_q & ~&pix_per_q & |act_cnt_q;
  assign line_diff = (line_per_q >= ref_line_q) ? line_per_q - ref_line_q : ref_line_q - line_per_q;
  assign m_match   = (line_diff <= 16'(LINE_TOL)) && (pix_per_q == ref_pix_q) && (act_cnt_q == ref_lines_q);
  assign pend      = (sd_req_q ^ app_sd_q) | (hq_req_q ^ app_hq_q);
  assign allow     = ref_line_q >= 16'(MIN_LINE_CLKS);
  assign match_d   = match_cnt_q + 4'd1;
  // input registration, edge history, period/line counters and vsync watchdog
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      {ce_q, hs_q, vs_q, hb_q, vb_q} <= '0;
      {ce_p_q, hs_p_q, vs_p_q, hb_p_q} <= '0;
      {sd_req_q, hq_req_q} <= '0;
      line_cnt_q <= '0;
      line_per_q <= '0;
      pix_cnt_q  <= '0;
      pix_per_q  <= '0;
      act_cnt_q  <= '0;
      to_q       <= '0;
    end else begin
      {ce_q, hs_q, vs_q, hb_q, vb_q} <= {ce_pix, hs_in, vs_in, hb_in, vb_in};
      {ce_p_q, hs_p_q, vs_p_q, hb_p_q} <= {ce_q, hs_q, vs_q, hb_q};
      {sd_req_q, hq_req_q} <= {sd_req, hq2x_req};
      line_cnt_q <= hs_rise ? '0 : line_d;
      if (hs_rise) line_per_q <= line_d;
      pix_cnt_q <= ce_rise ? '0 : pix_d;
      if (ce_rise && !hb_q && !vb_q) pix_per_q <= pix_d;
      if (fe) act_cnt_q <= '0;
      else if (hb_fall && !vb_q && !(&act_cnt_q)) act_cnt_q <= act_cnt_q + 10'd1;
      to_q <= fe ? '0 : (to_sat ? to_q : to_q + TIMEOUT_LOG2'(1));
    end
  end
  // mode FSM: qualify over frames, apply config at frame end, drop lock on change or vsync loss
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      state_q      <= UNLOCK;
      ref_line_q   <= '0;
      ref_pix_q    <= '0;
      ref_lines_q  <= '0;
      match_cnt_q  <= '0;
      mute_cnt_q   <= '0;
      app_sd_q     <= 1'b0;
      app_hq_q     <= 1'b0;
      sd_en        <= 1'b0;
      hq2x_en      <= 1'b0;
      mute         <= 1'b1;
      mode_valid   <= 1'b0;
      line_clks    <= '0;
      pix_clks     <= '0;
      active_lines <= '0;
    end else if (to_sat) begin
      state_q    <= UNLOCK;
      mute       <= 1'b1;
      mode_valid <= 1'b0;
    end else begin
      case (state_q)
        UNLOCK: if (fe && m_valid) begin
          {ref_line_q, ref_pix_q, ref_lines_q} <= {line_per_q, pix_per_q, act_cnt_q};
          match_cnt_q <= '0;
          state_q     <= CHECK;
        end
        CHECK: if (fe) begin
          if (!m_valid) state_q <= UNLOCK;
          else if (!m_match) begin
            {ref_line_q, ref_pix_q, ref_lines_q} <= {line_per_q, pix_per_q, act_cnt_q};
            match_cnt_q <= '0;
          end else begin
            match_cnt_q <= match_d;
            if (match_d >= 4'(STABLE_FRAMES - 1)) state_q <= APPLY;
          end
        end
        APPLY: begin
          sd_en        <= sd_req_q & allow;
          hq2x_en      <= sd_req_q & allow & hq_req_q;
          app_sd_q     <= sd_req_q;
          app_hq_q     <= hq_req_q;
          line_clks    <= ref_line_q;
          pix_clks     <= ref_pix_q;
          active_lines <= ref_lines_q;
          mode_valid   <= 1'b1;
          mute_cnt_q   <= 4'(MUTE_FRAMES);
          mute         <= MUTE_FRAMES != 0;
          state_q      <= LOCK;
        end
        LOCK: if (fe) begin
          if (!m_valid || !m_match) begin
            mute       <= 1'b1;
            mode_valid <= 1'b0;
            {ref_line_q, ref_pix_q, ref_lines_q} <= {line_per_q, pix_per_q, act_cnt_q};
            match_cnt_q <= '0;
            state_q    <= m_valid ? CHECK : UNLOCK;
          end else if (pend) state_q <= APPLY;
          else if (|mute_cnt_q) begin
            mute_cnt_q <= mute_cnt_q - 4'd1;
            if (mute_cnt_q == 4'd1) mute <= 1'b0;
          end
        end
        default: state_q <= UNLOCK;
      endcase
    end
  end
endmodule
